// File: rtl/pe_feed_sched.sv
// pe_feed_sched: drives the per-row PE input buffer read strobes with a
// diagonal wavefront skew (row r lags row 0 by r step-cycles), then waits a
// fixed drain time for the array to flush and pulses done.

// One row's read window: active for t in [ROW, ROW+len) while enabled.
module pe_feed_row #(
    parameter int CNTW = 8,
    parameter int ROW  = 0
) (
    input  logic            en,
    input  logic [CNTW+1:0] t_x,
    input  logic [CNTW+1:0] len_x,
    output logic            rd
);
    localparam logic [CNTW+1:0] ROW_X = (CNTW+2)'(ROW);

    // Widened compare so ROW+len never wraps.
    assign rd = en && (t_x >= ROW_X) && (t_x < ROW_X + len_x);
endmodule

module pe_feed_sched #(
    parameter int ROWS      = 8,
    parameter int CNTW      = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [CNTW-1:0] len,
    input  logic            step,
    input  logic            abort,
    output logic [ROWS-1:0] rd_en,
    output logic [CNTW:0]   feed_cnt,
    output logic            busy,
    output logic            done,
    output logic            len_err
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t          state;
    logic [CNTW-1:0] len_q;
    logic [CNTW:0]   t_q;
    logic [DW-1:0]   dcnt;

    logic [CNTW+1:0] t_x;
    logic [CNTW+1:0] len_x;
    logic [CNTW+1:0] last_x;
    logic            feed_en;

    assign t_x     = {1'b0, t_q};
    assign len_x   = {2'b00, len_q};
    // Final wavefront index: last row's last word, L+ROWS-2.
    assign last_x  = len_x + (CNTW+2)'(ROWS - 1) - (CNTW+2)'(1);
    // abort wins over step and kills strobes in the same cycle.
    assign feed_en = (state == FEED) && step && !abort;
    assign feed_cnt = t_q;

    // Per-row read window comparators.
    genvar r;
    generate
        for (r = 0; r < ROWS; r++) begin : g_row
            pe_feed_row #(.CNTW(CNTW), .ROW(r)) u_row (
                .en    (feed_en),
                .t_x   (t_x),
                .len_x (len_x),
                .rd    (rd_en[r])
            );
        end
    endgenerate

    // Pass sequencing FSM with registered busy/done/len_err.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            len_q   <= '0;
            t_q     <= '0;
            dcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    t_q <= '0;
                    if (start && !abort) begin
                        if (len == '0) begin
                            len_err <= 1'b1;
                        end else begin
                            len_q <= len;
                            state <= FEED;
                            busy  <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        t_q   <= '0;
                    end else if (step) begin
                        if (t_x == last_x) begin
                            state <= DRAIN;
                            dcnt  <= DW'(DRAIN_CYC - 1);
                        end else begin
                            t_q <= t_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        t_q   <= '0;
                    end else if (step) begin
                        if (dcnt == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    t_q   <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    t_q   <= '0;
                end
            endcase
        end
    end
endmodule
